chunk_load_ctrl: RTL and testbench
==================================

CHUNK_LOAD_CTRL -- requirements
Module: chunk_load_ctrl

Interface
REQ-001 SHALL have parameter MEM_SIZE, default 512, bytes per Data_Chunk bank.
REQ-002 SHALL have parameter BUS_SIZE, default 128, bytes per write beat; WR_CYC_NUM = MEM_SIZE/BUS_SIZE (default 4), CNT_W = $clog2(WR_CYC_NUM).
REQ-003 SHALL have port clk_i, input, 1, the single clock; all state is updated on its rising edge.
REQ-004 SHALL have port rst_ni, input, 1, reset; asynchronous assertion, active-low.
REQ-005 SHALL have port flush_i, input, 1, synchronous abort of all banks.
REQ-006 SHALL have port in_valid_i, input, 1, producer beat valid.
REQ-007 SHALL have port in_ready_o, output, 1, controller accepts beat.
REQ-008 SHALL have port in_sparsemap_i, input, BUS_SIZE, sparsemap slice of the beat.
REQ-009 SHALL have port in_nonzero_data_i, input, BUS_SIZE x 8, nonzero bytes of the beat.
REQ-010 SHALL have port wr_sparsemap_o, output, BUS_SIZE, registered sparsemap to both banks.
REQ-011 SHALL have port wr_nonzero_data_o, output, BUS_SIZE x 8, registered data to both banks.
REQ-012 SHALL have port wr_valid_o, output, 2, per-bank write strobe (bit b drives bank b).
REQ-013 SHALL have port wr_count_o, output, CNT_W, beat index within the chunk.
REQ-014 SHALL have port rd_start_o, output, 1, one-cycle pulse: bank rd_bank_o ready for the consumer.
REQ-015 SHALL have port rd_bank_o, output, 1, bank the consumer is to read.
REQ-016 SHALL have port rd_done_i, input, 1, consumer pulse: current read bank released.
REQ-017 SHALL have port bank_full_o, output, 2, bank b holds a complete chunk (FULL or READING).
REQ-018 SHALL have port err_o, output, 1, sticky protocol error flag.

Function
REQ-019 SHALL keep per-bank state: EMPTY, FILLING, FULL, READING; banks are used ping-pong.
REQ-020 SHALL keep fill_bank, fill_cnt (CNT_W) and rd_bank pointers.
REQ-021 SHALL drive in_ready_o = 1 iff state[fill_bank] is EMPTY or FILLING and flush_i = 0 (combinational).
REQ-022 SHALL accept a beat when in_valid_i & in_ready_o; next cycle wr_valid_o[fill_bank] = 1, wr_count_o = fill_cnt, wr_* data = captured beat (latency 1).
REQ-023 SHALL hold wr_valid_o = 2'b00 in cycles without a registered beat; wr data/count hold last value.
REQ-024 SHALL on acceptance move bank EMPTY->FILLING and increment fill_cnt; at fill_cnt = WR_CYC_NUM-1 wrap fill_cnt to 0 and toggle fill_bank.
REQ-025 SHALL move a bank FILLING->FULL at the edge its wr_valid_o with wr_count_o = WR_CYC_NUM-1 is presented (memory write edge).
REQ-026 SHALL, when state[rd_bank] = FULL and no bank is READING, move it to READING and pulse rd_start_o high with rd_bank_o = rd_bank on the following cycle.
REQ-027 SHALL on rd_done_i in READING move that bank to EMPTY and toggle rd_bank; rd_bank_o holds its value until the next rd_start_o.
REQ-028 SHALL allow accept of a beat into one bank, FULL transition and rd_done_i on the other bank in the same cycle, each applied independently.
REQ-029 SHALL ignore rd_done_i when no bank is READING and set err_o.
REQ-030 SHALL deassert in_ready_o when both banks are FULL/READING (full backpressure), and not drop or duplicate beats.
REQ-031 SHALL on flush_i set both banks EMPTY, fill_bank = rd_bank = 0, fill_cnt = 0, wr_valid_o = 0, rd_start_o = 0; err_o unchanged; rd_done_i that cycle ignored without error.

Reset
REQ-032 SHALL on rst_ni = 0 immediately force: both banks EMPTY, fill_bank = rd_bank = 0, fill_cnt = 0, in_ready_o = 0 while in reset, wr_valid_o = 0, wr_count_o = 0, wr data = 0, rd_start_o = 0, rd_bank_o = 0, bank_full_o = 0, err_o = 0.
REQ-033 SHALL discard any partially filled chunk on reset mid-operation and resume with bank 0, beat 0 after release.

Verification
REQ-034 Four back-to-back beats, default params -> wr_valid_o = 01 with wr_count_o 0,1,2,3 in cycles 1..4 after first accept; bank_full_o = 01 after 4th write; rd_start_o pulse with rd_bank_o = 0 next cycle.
REQ-035 Eight beats, no rd_done_i -> bank 0 then bank 1 filled, bank_full_o = 11, in_ready_o = 0, 9th beat held; rd_done_i -> bank 0 EMPTY, in_ready_o = 1, rd_start_o pulse with rd_bank_o = 1.
REQ-036 in_valid_i toggled every other cycle -> wr_count_o still 0..3 contiguous, no duplicated or missed beats.
REQ-037 rd_done_i with no bank READING -> err_o = 1 and stays 1; no state change.
REQ-038 flush_i after 2 beats into bank 0 -> next beat written with wr_valid_o = 01, wr_count_o = 0.
REQ-039 rst_ni low during beat 3 of bank 1 -> all outputs at reset values asynchronously; after release, first beat writes bank 0 count 0.

Source files
------------

// File: rtl/chunk_load_ctrl.sv
// Ping-pong loader: packs producer beats into two Data_Chunk banks and hands full
// banks to the consumer in order.
module chunk_load_ctrl #(
    parameter int unsigned MEM_SIZE   = 512,
    parameter int unsigned BUS_SIZE   = 128,
    localparam int unsigned WR_CYC_NUM = MEM_SIZE / BUS_SIZE,
    localparam int unsigned CNT_W      = (WR_CYC_NUM > 1) ? $clog2(WR_CYC_NUM) : 1
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  flush_i,
    input  logic                  in_valid_i,
    output logic                  in_ready_o,
    input  logic [BUS_SIZE-1:0]   in_sparsemap_i,
    input  logic [BUS_SIZE*8-1:0] in_nonzero_data_i,
    output logic [BUS_SIZE-1:0]   wr_sparsemap_o,
    output logic [BUS_SIZE*8-1:0] wr_nonzero_data_o,
    output logic [1:0]            wr_valid_o,
    output logic [CNT_W-1:0]      wr_count_o,
    output logic                  rd_start_o,
    output logic                  rd_bank_o,
    input  logic                  rd_done_i,
    output logic [1:0]            bank_full_o,
    output logic                  err_o
);

    typedef enum logic [1:0] {StEmpty, StFilling, StFull, StReading} bank_st_e;

    localparam logic [CNT_W-1:0] LastCnt = CNT_W'(WR_CYC_NUM - 1);

    bank_st_e              state_q [2];
    bank_st_e              state_d [2];
    logic                  fill_bank_q, fill_bank_d;
    logic [CNT_W-1:0]      fill_cnt_q, fill_cnt_d;
    logic                  rd_bank_q, rd_bank_d;
    logic                  err_q, err_d;
    logic                  rd_start_q, rd_start_d;
    logic                  rd_bank_out_q, rd_bank_out_d;
    logic [1:0]            wr_valid_q, wr_valid_d;
    logic [CNT_W-1:0]      wr_count_q, wr_count_d;
    logic [BUS_SIZE-1:0]   wr_sparse_q, wr_sparse_d;
    logic [BUS_SIZE*8-1:0] wr_data_q, wr_data_d;
    logic                  accept;
    logic                  any_reading;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q[0]    <= StEmpty;
            state_q[1]    <= StEmpty;
            fill_bank_q   <= 1'b0;
            fill_cnt_q    <= '0;
            rd_bank_q     <= 1'b0;
            err_q         <= 1'b0;
            rd_start_q    <= 1'b0;
            rd_bank_out_q <= 1'b0;
            wr_valid_q    <= '0;
            wr_count_q    <= '0;
            wr_sparse_q   <= '0;
            wr_data_q     <= '0;
        end else begin
            state_q[0]    <= state_d[0];
            state_q[1]    <= state_d[1];
            fill_bank_q   <= fill_bank_d;
            fill_cnt_q    <= fill_cnt_d;
            rd_bank_q     <= rd_bank_d;
            err_q         <= err_d;
            rd_start_q    <= rd_start_d;
            rd_bank_out_q <= rd_bank_out_d;
            wr_valid_q    <= wr_valid_d;
            wr_count_q    <= wr_count_d;
            wr_sparse_q   <= wr_sparse_d;
            wr_data_q     <= wr_data_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        fill_bank_d   = fill_bank_q;
        fill_cnt_d    = fill_cnt_q;
        rd_bank_d     = rd_bank_q;
        err_d         = err_q;
        rd_start_d    = 1'b0;
        rd_bank_out_d = rd_bank_out_q;
        wr_valid_d    = '0;
        wr_count_d    = wr_count_q;
        wr_sparse_d   = wr_sparse_q;
        wr_data_d     = wr_data_q;
        any_reading   = (state_q[0] == StReading) || (state_q[1] == StReading);
        if (flush_i) begin
            state_d[0]  = StEmpty;
            state_d[1]  = StEmpty;
            fill_bank_d = 1'b0;
            fill_cnt_d  = '0;
            rd_bank_d   = 1'b0;
        end else begin
            if (accept) begin
                wr_valid_d[fill_bank_q] = 1'b1;
                wr_count_d              = fill_cnt_q;
                wr_sparse_d             = in_sparsemap_i;
                wr_data_d               = in_nonzero_data_i;
                if (state_q[fill_bank_q] == StEmpty) state_d[fill_bank_q] = StFilling;
                if (fill_cnt_q == LastCnt) begin
                    fill_cnt_d  = '0;
                    fill_bank_d = ~fill_bank_q;
                end else begin
                    fill_cnt_d = fill_cnt_q + CNT_W'(1);
                end
            end
            // Bank is complete once its last beat has been written into memory.
            for (int b = 0; b < 2; b++) begin
                if (wr_valid_q[b] && wr_count_q == LastCnt && state_q[b] == StFilling) begin
                    state_d[b] = StFull;
                end
            end
            if (rd_done_i) begin
                if (any_reading) begin
                    state_d[rd_bank_q] = StEmpty;
                    rd_bank_d          = ~rd_bank_q;
                end else begin
                    err_d = 1'b1;
                end
            end else if (!any_reading && state_q[rd_bank_q] == StFull) begin
                state_d[rd_bank_q] = StReading;
                rd_start_d         = 1'b1;
                rd_bank_out_d      = rd_bank_q;
            end
        end
    end

    always_comb begin
        in_ready_o = rst_ni && !flush_i &&
                     (state_q[fill_bank_q] == StEmpty || state_q[fill_bank_q] == StFilling);
        accept     = in_valid_i && in_ready_o;
        for (int b = 0; b < 2; b++) begin
            bank_full_o[b] = (state_q[b] == StFull) || (state_q[b] == StReading);
        end
        wr_valid_o        = wr_valid_q;
        wr_count_o        = wr_count_q;
        wr_sparsemap_o    = wr_sparse_q;
        wr_nonzero_data_o = wr_data_q;
        rd_start_o        = rd_start_q;
        rd_bank_o         = rd_bank_out_q;
        err_o             = err_q;
    end

endmodule

// File: tb/tb_chunk_load_ctrl.sv
// Directed bench for chunk_load_ctrl with default parameters (4 beats per chunk).
module tb_chunk_load_ctrl;

    logic          clk_i = 1'b0;
    logic          rst_ni;
    logic          flush_i;
    logic          in_valid_i;
    logic          in_ready_o;
    logic [127:0]  in_sparsemap_i;
    logic [1023:0] in_nonzero_data_i;
    logic [127:0]  wr_sparsemap_o;
    logic [1023:0] wr_nonzero_data_o;
    logic [1:0]    wr_valid_o;
    logic [1:0]    wr_count_o;
    logic          rd_start_o;
    logic          rd_bank_o;
    logic          rd_done_i;
    logic [1:0]    bank_full_o;
    logic          err_o;

    int total = 0;
    int bad   = 0;

    chunk_load_ctrl dut (
        .clk_i             (clk_i),
        .rst_ni            (rst_ni),
        .flush_i           (flush_i),
        .in_valid_i        (in_valid_i),
        .in_ready_o        (in_ready_o),
        .in_sparsemap_i    (in_sparsemap_i),
        .in_nonzero_data_i (in_nonzero_data_i),
        .wr_sparsemap_o    (wr_sparsemap_o),
        .wr_nonzero_data_o (wr_nonzero_data_o),
        .wr_valid_o        (wr_valid_o),
        .wr_count_o        (wr_count_o),
        .rd_start_o        (rd_start_o),
        .rd_bank_o         (rd_bank_o),
        .rd_done_i         (rd_done_i),
        .bank_full_o       (bank_full_o),
        .err_o             (err_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic tick();
        @(posedge clk_i);
        #2;
    endtask

    task automatic set_beat(input int k);
        in_sparsemap_i           = '0;
        in_nonzero_data_i        = '0;
        in_sparsemap_i[15:0]     = 16'hA000 + 16'(k);
        in_nonzero_data_i[31:0]  = 32'hD000_0000 + 32'(k);
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_beat(input string tag, input logic [1:0] vld, input int cnt, input int k);
        chk({tag, "_vld"}, 64'(wr_valid_o), 64'(vld));
        chk({tag, "_cnt"}, 64'(wr_count_o), 64'(cnt));
        chk({tag, "_data"}, 64'(wr_nonzero_data_o[31:0]), 64'(32'hD000_0000 + 32'(k)));
        chk({tag, "_smap"}, 64'(wr_sparsemap_o[15:0]), 64'(16'hA000 + 16'(k)));
    endtask

    initial begin
        rst_ni     = 1'b0;
        flush_i    = 1'b0;
        in_valid_i = 1'b0;
        rd_done_i  = 1'b0;
        set_beat(0);
        #3;
        chk("rst_vld", 64'(wr_valid_o), 64'd0);
        chk("rst_ready", 64'(in_ready_o), 64'd0);
        chk("rst_full", 64'(bank_full_o), 64'd0);
        chk("rst_err", 64'(err_o), 64'd0);
        chk("rst_start", 64'(rd_start_o), 64'd0);
        @(negedge clk_i);
        rst_ni = 1'b1;
        tick();
        chk("idle_ready", 64'(in_ready_o), 64'd1);

        // Four back-to-back beats into bank 0, then hand-off to the reader.
        in_valid_i = 1'b1;
        for (int k = 0; k < 4; k++) begin
            set_beat(k);
            tick();
            chk_beat("b2b", 2'b01, k, k);
        end
        in_valid_i = 1'b0;
        chk("b2b_full_pre", 64'(bank_full_o), 64'd0);
        tick();
        chk("b2b_full", 64'(bank_full_o), 64'b01);
        chk("b2b_vld_idle", 64'(wr_valid_o), 64'd0);
        chk("b2b_start_pre", 64'(rd_start_o), 64'd0);
        tick();
        chk("b2b_start", 64'(rd_start_o), 64'd1);
        chk("b2b_rdbank", 64'(rd_bank_o), 64'd0);
        tick();
        chk("b2b_start_pulse", 64'(rd_start_o), 64'd0);
        rd_done_i = 1'b1;
        tick();
        rd_done_i = 1'b0;
        chk("done0_full", 64'(bank_full_o), 64'd0);
        chk("done0_err", 64'(err_o), 64'd0);

        // Gapped producer into bank 1.
        for (int k = 0; k < 4; k++) begin
            in_valid_i = 1'b1;
            set_beat(10 + k);
            tick();
            chk_beat("gap", 2'b10, k, 10 + k);
            in_valid_i = 1'b0;
            tick();
            chk("gap_idle_vld", 64'(wr_valid_o), 64'd0);
            chk("gap_idle_cnt", 64'(wr_count_o), 64'(k));
        end
        chk("gap_full", 64'(bank_full_o), 64'b10);
        tick();
        chk("gap_start", 64'(rd_start_o), 64'd1);
        chk("gap_rdbank", 64'(rd_bank_o), 64'd1);
        rd_done_i = 1'b1;
        tick();
        rd_done_i = 1'b0;
        chk("done1_full", 64'(bank_full_o), 64'd0);

        // Stray rd_done: sticky error, no state change.
        rd_done_i = 1'b1;
        tick();
        rd_done_i = 1'b0;
        chk("stray_err", 64'(err_o), 64'd1);
        chk("stray_full", 64'(bank_full_o), 64'd0);
        chk("stray_ready", 64'(in_ready_o), 64'd1);
        tick();
        chk("stray_err_sticky", 64'(err_o), 64'd1);

        // Eight beats with no consumer release: full backpressure.
        in_valid_i = 1'b1;
        for (int i = 0; i < 8; i++) begin
            set_beat(20 + i);
            #1;
            chk("bp_ready", 64'(in_ready_o), 64'd1);
            tick();
            chk_beat("bp", (i < 4) ? 2'b01 : 2'b10, i % 4, 20 + i);
        end
        set_beat(28);
        #1;
        chk("bp_held_ready", 64'(in_ready_o), 64'd0);
        tick();
        chk("bp_held_vld", 64'(wr_valid_o), 64'd0);
        chk("bp_full", 64'(bank_full_o), 64'b11);
        chk("bp_ready_full", 64'(in_ready_o), 64'd0);
        tick();
        chk("bp_held_vld2", 64'(wr_valid_o), 64'd0);
        rd_done_i = 1'b1;
        tick();
        rd_done_i = 1'b0;
        chk("bp_rel_ready", 64'(in_ready_o), 64'd1);
        chk("bp_rel_full", 64'(bank_full_o), 64'b10);
        chk("bp_rel_start_pre", 64'(rd_start_o), 64'd0);
        tick();
        chk("bp_rel_start", 64'(rd_start_o), 64'd1);
        chk("bp_rel_rdbank", 64'(rd_bank_o), 64'd1);
        chk_beat("bp_ninth", 2'b01, 0, 28);

        // Second beat into bank 0, then flush.
        set_beat(29);
        tick();
        chk_beat("pre_flush", 2'b01, 1, 29);
        in_valid_i = 1'b0;
        flush_i    = 1'b1;
        rd_done_i  = 1'b1;
        #1;
        chk("flush_ready", 64'(in_ready_o), 64'd0);
        tick();
        flush_i   = 1'b0;
        rd_done_i = 1'b0;
        chk("flush_vld", 64'(wr_valid_o), 64'd0);
        chk("flush_full", 64'(bank_full_o), 64'd0);
        chk("flush_err_kept", 64'(err_o), 64'd1);
        chk("flush_start", 64'(rd_start_o), 64'd0);
        in_valid_i = 1'b1;
        set_beat(30);
        tick();
        chk_beat("post_flush", 2'b01, 0, 30);

        // Reset in the middle of bank 1's third beat.
        for (int i = 0; i < 6; i++) begin
            set_beat(31 + i);
            tick();
        end
        chk_beat("pre_rst", 2'b10, 2, 36);
        #1;
        rst_ni     = 1'b0;
        in_valid_i = 1'b0;
        #1;
        chk("arst_vld", 64'(wr_valid_o), 64'd0);
        chk("arst_cnt", 64'(wr_count_o), 64'd0);
        chk("arst_data", 64'(wr_nonzero_data_o[63:0]), 64'd0);
        chk("arst_smap", 64'(wr_sparsemap_o[63:0]), 64'd0);
        chk("arst_start", 64'(rd_start_o), 64'd0);
        chk("arst_rdbank", 64'(rd_bank_o), 64'd0);
        chk("arst_full", 64'(bank_full_o), 64'd0);
        chk("arst_err", 64'(err_o), 64'd0);
        chk("arst_ready", 64'(in_ready_o), 64'd0);
        @(negedge clk_i);
        rst_ni = 1'b1;
        tick();
        in_valid_i = 1'b1;
        set_beat(40);
        tick();
        in_valid_i = 1'b0;
        chk_beat("post_rst", 2'b01, 0, 40);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
